mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multicycle load/store bus master between the datapath's address/data registers and the memory/IO bus.
- Aligns store data and generates byte masks, issues word-aligned bus transactions with a valid/ready handshake, and captures read words.
- Returns the raw read word, addr[1:0] and the load op downstream to the load alignment stage.
- Detects misaligned accesses and bus timeouts, and reports them as errors without touching the bus.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_valid may stay high without mem_ready; 0 disables the timeout.
- TO_WIDTH, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**TO_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  access request from control FSM
- req_ready  output  1  unit idle, can accept a request
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- req_loadop  input  `LOAD_OP_WIDTH  LB/LH/LW/LBU/LHU
- req_storeop  input  `STORE_OP_WIDTH  SB/SH/SW
- mem_valid  output  1  bus request
- mem_ready  input  1  bus completion
- mem_addr  output  32  word address {req_addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wmask  output  4  byte enables; 4'b0000 for loads
- mem_rdata  input  32  bus read word, valid when mem_valid&mem_ready
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  captured raw read word (0 for stores/errors)
- rsp_addr_lo  output  2  latched req_addr[1:0]
- rsp_loadop  output  `LOAD_OP_WIDTH  latched load op
- rsp_misaligned  output  1  with rsp_valid: access was misaligned
- rsp_timeout  output  1  with rsp_valid: bus did not answer

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - mem_valid=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_timeout=0, rsp_addr_lo=0, rsp_loadop=0.
  - Timeout counter=0.
  - Reset mid-transaction drops mem_valid on the next edge; no rsp_valid is produced.
- req_ready = (state==IDLE); combinational from state only.
- States: IDLE, BUS, RESP.
- IDLE + req_valid: latch addr_lo, loadop, we.
  - Misaligned means: halfword op with addr[0]=1, or word op with addr[1:0]!=0.
  - Misaligned -> RESP with rsp_misaligned=1. mem_valid never asserts.
  - Otherwise -> BUS, with mem_valid=1 and mem_addr/mem_wdata/mem_wmask registered in the same edge.
- Store alignment:
  - SB: wdata={4{d[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wmask=addr[1]?4'b1100:4'b0011.
  - SW: wdata=d, wmask=4'b1111.
  - Loads: wmask=4'b0000, mem_wdata=0.
- BUS: mem_valid, mem_addr, mem_wdata and mem_wmask are held stable until completion.
  - mem_ready sampled high: capture mem_rdata into rsp_rdata (loads only; stores capture 0), drop mem_valid, go to RESP.
  - mem_ready may already be high on the first BUS cycle, giving the minimum latency.
  - Counter increments each BUS cycle without mem_ready.
  - Counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0): drop mem_valid, set rsp_timeout=1, go to RESP.
  - mem_ready and the timeout in the same cycle: mem_ready wins, no timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Error flags and rsp_rdata hold until the next RESP.
  - Counter clears on entering IDLE.
- Latency, aligned access with immediate ready:
  - Accept edge -> mem_valid high 1 cycle -> rsp_valid on the following cycle.
  - Total 3 cycles from request to next req_ready.
- Misaligned access: rsp_valid is 1 cycle after accept.
- req_valid while not IDLE is ignored; there is no queueing.
- mem_ready outside BUS is ignored.

Test Plan:
- Load LW, addr=0x100, mem_ready immediate, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_wmask=0; rsp_valid 2 cycles after accept with rsp_rdata=0xDEADBEEF, rsp_addr_lo=0, no error flags.
- Store SB, addr=0x203, wdata=0x000000A5 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_wmask=4'b1000. Store SH, addr=0x202, wdata=0x1234 -> mem_wdata=0x12341234, mem_wmask=4'b1100.
- Load LH, addr=0x101 -> mem_valid never asserts; rsp_valid 1 cycle after accept with rsp_misaligned=1. Same for SW at addr=0x102.
- LBU, addr=0x6, mem_ready held low 5 cycles -> mem_valid, mem_addr=0x4 and mem_wmask remain stable all 6 BUS cycles; response after ready with rsp_addr_lo=2.
- TIMEOUT_CYCLES=4, mem_ready never asserts -> mem_valid drops after the 4th BUS cycle; rsp_timeout=1, rsp_rdata=0. Repeat with mem_ready asserted exactly on the 4th cycle -> normal completion, rsp_timeout=0.
- reset pulsed while in BUS -> mem_valid=0 and req_ready=1 next cycle, no rsp_valid; a following LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multicycle load/store bus master: aligns store data, drives a word-aligned valid/ready
// bus transaction, and returns the raw read word with misalignment/timeout status.
`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`endif
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [`LOAD_OP_WIDTH-1:0]  req_loadop,
  input  logic [`STORE_OP_WIDTH-1:0] req_storeop,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wmask,
  input  logic [31:0]                mem_rdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic [1:0]                 rsp_addr_lo,
  output logic [`LOAD_OP_WIDTH-1:0]  rsp_loadop,
  output logic                       rsp_misaligned,
  output logic                       rsp_timeout
);

  localparam logic [`LOAD_OP_WIDTH-1:0]  LD_LH  = 3'b001;
  localparam logic [`LOAD_OP_WIDTH-1:0]  LD_LW  = 3'b010;
  localparam logic [`LOAD_OP_WIDTH-1:0]  LD_LHU = 3'b101;
  localparam logic [`STORE_OP_WIDTH-1:0] ST_SB  = 2'b00;
  localparam logic [`STORE_OP_WIDTH-1:0] ST_SH  = 2'b01;
  localparam logic [`STORE_OP_WIDTH-1:0] ST_SW  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  function automatic logic [31:0] align_wdata(input logic [`STORE_OP_WIDTH-1:0] op,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (op)
      ST_SB:   r = {4{d[7:0]}};
      ST_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] align_wmask(input logic [`STORE_OP_WIDTH-1:0] op,
                                             input logic [1:0] lo);
    logic [3:0] m;
    case (op)
      ST_SB:   m = 4'b0001 << lo;
      ST_SH:   m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic we,
                                         input logic [`LOAD_OP_WIDTH-1:0] lop,
                                         input logic [`STORE_OP_WIDTH-1:0] sop,
                                         input logic [1:0] lo);
    logic half;
    logic word;
    if (we) begin
      half = (sop == ST_SH);
      word = (sop == ST_SW);
    end else begin
      half = (lop == LD_LH) || (lop == LD_LHU);
      word = (lop == LD_LW);
    end
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

  state_t                      state_q, state_d;
  logic                        we_q, we_d;
  logic [TO_WIDTH-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                        timeout_hit;
  logic                        mem_valid_q, mem_valid_d;
  logic [31:0]                 mem_addr_q, mem_addr_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
  logic [3:0]                  mem_wmask_q, mem_wmask_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_addr_lo_q, rsp_addr_lo_d;
  logic [`LOAD_OP_WIDTH-1:0]   rsp_loadop_q, rsp_loadop_d;
  logic                        rsp_mis_q, rsp_mis_d;
  logic                        rsp_to_q, rsp_to_d;

  assign req_ready      = (state_q == IDLE);
  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_addr_lo    = rsp_addr_lo_q;
  assign rsp_loadop     = rsp_loadop_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_timeout    = rsp_to_q;

  assign cnt_inc     = cnt_q + {{(TO_WIDTH-1){1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_inc == TO_WIDTH'(TIMEOUT_CYCLES));

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_addr_lo_d = rsp_addr_lo_q;
    rsp_loadop_d  = rsp_loadop_q;
    rsp_mis_d     = rsp_mis_q;
    rsp_to_d      = rsp_to_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          we_d          = req_we;
          rsp_addr_lo_d = req_addr[1:0];
          rsp_loadop_d  = req_loadop;
          if (is_misaligned(req_we, req_loadop, req_storeop, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
            rsp_to_d    = 1'b0;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_we ? align_wdata(req_storeop, req_wdata) : 32'h0000_0000;
            mem_wmask_d = req_we ? align_wmask(req_storeop, req_addr[1:0]) : 4'b0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // A ready in the same cycle as the timeout takes priority.
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0000_0000 : mem_rdata;
          rsp_mis_d   = 1'b0;
          rsp_to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          rsp_mis_d   = 1'b0;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      mem_wmask_q   <= 4'b0000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
      rsp_addr_lo_q <= 2'b00;
      rsp_loadop_q  <= '0;
      rsp_mis_q     <= 1'b0;
      rsp_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_addr_lo_q <= rsp_addr_lo_d;
      rsp_loadop_q  <= rsp_loadop_d;
      rsp_mis_q     <= rsp_mis_d;
      rsp_to_q      <= rsp_to_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit; instance A uses the default timeout,
// instance B a 4-cycle timeout, selected through a shared stimulus mux.
`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`endif
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif

module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, mem_rdata = 32'h0;
  logic [2:0]  req_loadop = 3'b000;
  logic [1:0]  req_storeop = 2'b00;

  logic        a_req_ready, a_mem_valid, a_rsp_valid, a_rsp_mis, a_rsp_to;
  logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_rdata;
  logic [3:0]  a_mem_wmask;
  logic [1:0]  a_rsp_lo;
  logic [2:0]  a_rsp_lop;
  logic        b_req_ready, b_mem_valid, b_rsp_valid, b_rsp_mis, b_rsp_to;
  logic [31:0] b_mem_addr, b_mem_wdata, b_rsp_rdata;
  logic [3:0]  b_mem_wmask;
  logic [1:0]  b_rsp_lo;
  logic [2:0]  b_rsp_lop;

  wire        o_req_ready = sel ? b_req_ready : a_req_ready;
  wire        o_mem_valid = sel ? b_mem_valid : a_mem_valid;
  wire [31:0] o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  wire [31:0] o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  wire [3:0]  o_mem_wmask = sel ? b_mem_wmask : a_mem_wmask;
  wire        o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  wire [31:0] o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  wire [1:0]  o_rsp_lo    = sel ? b_rsp_lo    : a_rsp_lo;
  wire [2:0]  o_rsp_lop   = sel ? b_rsp_lop   : a_rsp_lop;
  wire        o_rsp_mis   = sel ? b_rsp_mis   : a_rsp_mis;
  wire        o_rsp_to    = sel ? b_rsp_to    : a_rsp_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_loadop(req_loadop),
    .req_storeop(req_storeop), .mem_valid(a_mem_valid), .mem_ready(mem_ready & ~sel),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_rdata(mem_rdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_addr_lo(a_rsp_lo), .rsp_loadop(a_rsp_lop), .rsp_misaligned(a_rsp_mis),
    .rsp_timeout(a_rsp_to)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4), .TO_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_loadop(req_loadop),
    .req_storeop(req_storeop), .mem_valid(b_mem_valid), .mem_ready(mem_ready & sel),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_rdata(mem_rdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_addr_lo(b_rsp_lo), .rsp_loadop(b_rsp_lop), .rsp_misaligned(b_rsp_mis),
    .rsp_timeout(b_rsp_to)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one access and check it against an access-level model (size, alignment, wait states).
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] d, input logic [2:0] lop, input logic [1:0] sop,
                         input int delay, input logic [31:0] rd);
    int size, to_lim, bus_cycles;
    logic mis, tmo;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0] e_mask;
    to_lim = sel ? 4 : 255;
    if (we) size = (sop == SB) ? 1 : (sop == SH) ? 2 : 4;
    else    size = (lop == LB || lop == LBU) ? 1 : (lop == LH || lop == LHU) ? 2 : 4;
    mis     = (addr % size) != 0;
    tmo     = !mis && (delay >= to_lim);
    bus_cycles = mis ? 0 : (tmo ? to_lim : delay + 1);
    e_addr  = addr & 32'hFFFF_FFFC;
    e_wdata = !we ? 32'h0 : (size == 1) ? (d & 32'hFF) * 32'h0101_0101 :
              (size == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
    e_mask  = !we ? 4'h0 : 4'(((1 << size) - 1) << (addr % 4));
    e_rdata = (mis || tmo || we) ? 32'h0 : rd;

    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++; $display("FAIL %s.req_ready_idle got %b exp 1", name, o_req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d;
    req_loadop = lop; req_storeop = sop; mem_ready = 1'b0;
    step();
    for (int k = 0; k < bus_cycles; k++) begin
      checks++;
      if (o_mem_valid !== 1'b1 || o_mem_addr !== e_addr || o_mem_wdata !== e_wdata ||
          o_mem_wmask !== e_mask || o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s.bus[%0d] got v=%b a=%h d=%h m=%b rdy=%b rv=%b exp v=1 a=%h d=%h m=%b rdy=0 rv=0",
                 name, k, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wmask, o_req_ready,
                 o_rsp_valid, e_addr, e_wdata, e_mask);
      end
      // Ignored junk request while busy.
      req_valid = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_we = 1'($urandom);
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rd : $urandom;
      step();
    end
    mem_ready = 1'b0; mem_rdata = $urandom;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_mem_valid !== 1'b0 || o_rsp_rdata !== e_rdata ||
        o_rsp_mis !== mis || o_rsp_to !== tmo || o_rsp_lo !== addr[1:0] || o_rsp_lop !== lop) begin
      errors++;
      $display("FAIL %s.rsp got rv=%b mv=%b rd=%h mis=%b to=%b lo=%0d op=%0d exp rv=1 mv=0 rd=%h mis=%b to=%b lo=%0d op=%0d",
               name, o_rsp_valid, o_mem_valid, o_rsp_rdata, o_rsp_mis, o_rsp_to, o_rsp_lo,
               o_rsp_lop, e_rdata, mis, tmo, addr[1:0], lop);
    end
    req_valid = 1'b0;
    step();
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== e_rdata ||
        o_rsp_mis !== mis || o_rsp_to !== tmo || o_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s.after got rv=%b rdy=%b rd=%h mis=%b to=%b mv=%b exp rv=0 rdy=1 rd=%h mis=%b to=%b mv=0",
               name, o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_mis, o_rsp_to, o_mem_valid,
               e_rdata, mis, tmo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0 || o_mem_wmask !== 4'h0 ||
        o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_rsp_valid !== 1'b0 ||
        o_rsp_rdata !== 32'h0 || o_rsp_mis !== 1'b0 || o_rsp_to !== 1'b0 ||
        o_rsp_lo !== 2'd0 || o_rsp_lop !== 3'd0) begin
      errors++;
      $display("FAIL reset got rdy=%b mv=%b m=%b a=%h d=%h rv=%b rd=%h mis=%b to=%b lo=%0d op=%0d exp rdy=1 rest 0",
               o_req_ready, o_mem_valid, o_mem_wmask, o_mem_addr, o_mem_wdata, o_rsp_valid,
               o_rsp_rdata, o_rsp_mis, o_rsp_to, o_rsp_lo, o_rsp_lop);
    end
  endtask

  task automatic test_load_basic();
    sel = 1'b0;
    run_txn("lw_imm", 1'b0, 32'h100, 32'h0, LW, SW, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_store_align();
    sel = 1'b0;
    run_txn("sb_203", 1'b1, 32'h203, 32'h0000_00A5, LB, SB, 0, 32'h1111_2222);
    run_txn("sh_202", 1'b1, 32'h202, 32'h0000_1234, LB, SH, 1, 32'h3333_4444);
  endtask

  task automatic test_misaligned();
    sel = 1'b0;
    run_txn("lh_101", 1'b0, 32'h101, 32'h0, LH, SB, 0, 32'h5555_6666);
    run_txn("sw_102", 1'b1, 32'h102, 32'hCAFE_F00D, LW, SW, 0, 32'h7777_8888);
  endtask

  task automatic test_wait_states();
    sel = 1'b0;
    run_txn("lbu_wait", 1'b0, 32'h6, 32'h0, LBU, SB, 5, 32'h0BAD_F00D);
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    run_txn("to_none", 1'b0, 32'h40, 32'h0, LW, SW, 100, 32'h1234_5678);
    run_txn("to_edge", 1'b0, 32'h44, 32'h0, LW, SW, 3, 32'h8765_4321);
    run_txn("to_store", 1'b1, 32'h48, 32'hFFEE_DDCC, LB, SW, 7, 32'h0);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_loadop = LW; mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid.in_bus got mv=%b exp 1", o_mem_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid.after got mv=%b rdy=%b rv=%b exp mv=0 rdy=1 rv=0",
               o_mem_valid, o_req_ready, o_rsp_valid);
    end
    step();
    checks++;
    if (o_rsp_valid !== 1'b0 || o_mem_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid.quiet got rv=%b mv=%b exp 0 0", o_rsp_valid, o_mem_valid);
    end
    run_txn("rst_mid_lw", 1'b0, 32'h304, 32'h0, LW, SW, 0, 32'hA1B2_C3D4);
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] lops [5];
    logic [1:0] sops [3];
    lops = '{LB, LH, LW, LBU, LHU};
    sops = '{SB, SH, SW};
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom);
      run_txn("rand", 1'($urandom), $urandom, $urandom, lops[$urandom_range(0, 4)],
              sops[$urandom_range(0, 2)], int'($urandom_range(0, 6)), $urandom);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_align();
    test_misaligned();
    test_wait_states();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
